rom_page_ctrl: RTL

Parametrised page/column controller for the i4001 ROM programmer: owns the input-mode write pointer, the debug/run-mode scan pointer and page selection, drives the ROM address/write port and feeds the dot-matrix column path and 7-segment page number. Sits between the top-level switch/mode decode and the ROM, matrix and segment blocks. Unlike the previous top-level logic, it runs on one clock with a load handshake. It also has a configurable page geometry and an optional write-verify.

---
 rtl/rom_pkg.sv | 29 ++
 rtl/page_counter.sv | 36 +++
 rtl/rom_page_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rom_pkg.sv
// rom_pkg: shared definitions for the i4001 ROM programmer page/column controller.
//   - mode encoding constants for the 2-bit mode input (3 behaves as run)
//   - load FSM state encoding
//   - default page geometry
package rom_pkg;

    localparam logic [1:0] MODE_INPUT = 2'd0;
    localparam logic [1:0] MODE_RUN   = 2'd1;
    localparam logic [1:0] MODE_DEBUG = 2'd2;

    // StVerifyRd/StVerifyCmp are only reachable when write-verify is built in.
    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StVerifyRd,
        StVerifyCmp
    } load_state_e;

    localparam int unsigned DEF_DATA_W        = 16;
    localparam int unsigned DEF_COLS_PER_PAGE = 32;
    localparam int unsigned DEF_NUM_PAGES     = 64;
    localparam int unsigned DEF_PAGE_W        = 8;

    // Any non-input mode drives the scan pointer.
    function automatic logic is_scan_mode(input logic [1:0] m);
        return m != MODE_INPUT;
    endfunction

endpackage

// File: rtl/page_counter.sv
// page_counter: wrapping up/down page register for the debug/run page selection.
// Ports:
//   CLK, RESET  - system clock, synchronous active-high reset
//   en_i        - pulses are honoured only while high
//   up_i/down_i - one-cycle step pulses; both together cancel
//   count_o     - current page
//   changed_o   - high in the cycle whose edge will change the page
module page_counter
#(
    parameter  int unsigned NUM_PAGES = 64,
    localparam int unsigned PG_W      = $clog2(NUM_PAGES)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            en_i,
    input  logic            up_i,
    input  logic            down_i,
    output logic [PG_W-1:0] count_o,
    output logic            changed_o
);

    logic [PG_W-1:0] cnt_q;

    assign changed_o = en_i & (up_i ^ down_i);
    assign count_o   = cnt_q;

    // NUM_PAGES is a power of two, so plain modular arithmetic gives the wrap.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (changed_o) begin
            cnt_q <= up_i ? cnt_q + PG_W'(1) : cnt_q - PG_W'(1);
        end
    end

endmodule

// File: rtl/rom_page_ctrl.sv
// rom_page_ctrl: page/column controller for the i4001 ROM programmer.
// Input mode writes loaded words sequentially into the ROM; run/debug modes scan the
// selected page column by column into the dot-matrix path.
// Ports:
//   CLK, RESET            - system clock, synchronous active-high reset
//   mode                  - 0 input, 1 run, 2 debug, 3 as run
//   load_stb/load_ready   - load handshake, din is the word to write
//   page_up/page_down     - page step pulses (scan modes only)
//   rom_addr/we/wdata     - ROM write/read port, rom_rdata valid one cycle after address
//   disp_col/data/valid   - matrix column output
//   page                  - page number for the 7-segment display
//   load_done, err        - sticky: last word written / verify mismatch
// Build option: define ROM_PAGE_CTRL_VERIFY_EN to read back and compare each written word.
module rom_page_ctrl
    import rom_pkg::*;
#(
    parameter  int unsigned DATA_W        = DEF_DATA_W,
    parameter  int unsigned COLS_PER_PAGE = DEF_COLS_PER_PAGE,
    parameter  int unsigned NUM_PAGES     = DEF_NUM_PAGES,
    parameter  int unsigned PAGE_W        = DEF_PAGE_W,
    localparam int unsigned ADDR_W        = $clog2(NUM_PAGES * COLS_PER_PAGE),
    localparam int unsigned COL_W         = $clog2(COLS_PER_PAGE),
    localparam int unsigned PG_W          = $clog2(NUM_PAGES)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        mode,
    input  logic              load_stb,
    output logic              load_ready,
    input  logic [DATA_W-1:0] din,
    input  logic              page_up,
    input  logic              page_down,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_we,
    output logic [DATA_W-1:0] rom_wdata,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic [COL_W-1:0]  disp_col,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic [PAGE_W-1:0] page,
    output logic              load_done,
    output logic              err
);

    load_state_e       state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [DATA_W-1:0] din_q;
    logic              rom_we_q, load_ready_q, load_done_q;
    logic [COL_W-1:0]  scan_col_q, col_dly_q;
    logic [1:0]        mode_q;
    logic              valid_q;
    logic [PG_W-1:0]   dbg_page;
    logic              page_chg, pc_en, scan, mode_chg;
`ifdef ROM_PAGE_CTRL_VERIFY_EN
    logic [ADDR_W-1:0] wr_addr_q;
    logic              err_q;
`endif

    // Behaviour follows the registered mode; a differing input mode marks a change edge.
    assign scan     = is_scan_mode(mode_q);
    assign mode_chg = (mode != mode_q);
    assign pc_en    = scan & ~mode_chg;

    page_counter #(
        .NUM_PAGES (NUM_PAGES)
    ) u_page_counter (
        .CLK       (CLK),
        .RESET     (RESET),
        .en_i      (pc_en),
        .up_i      (page_up),
        .down_i    (page_down),
        .count_o   (dbg_page),
        .changed_o (page_chg)
    );

    // Load FSM with registered handshake/write-enable outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            din_q        <= '0;
            rom_we_q     <= 1'b0;
            load_ready_q <= 1'b1;
            load_done_q  <= 1'b0;
`ifdef ROM_PAGE_CTRL_VERIFY_EN
            wr_addr_q    <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!scan && !mode_chg && load_stb) begin
                        din_q        <= din;
                        state_q      <= StWrite;
                        rom_we_q     <= 1'b1;
                        load_ready_q <= 1'b0;
`ifdef ROM_PAGE_CTRL_VERIFY_EN
                        wr_addr_q    <= wr_ptr_q;
`endif
                    end
                end
                StWrite: begin
                    // The write itself always completes; only what follows can be aborted.
                    rom_we_q <= 1'b0;
                    wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                    if (&wr_ptr_q) begin
                        load_done_q <= 1'b1;
                    end
`ifdef ROM_PAGE_CTRL_VERIFY_EN
                    if (mode_chg) begin
                        state_q      <= StIdle;
                        load_ready_q <= 1'b1;
                    end else begin
                        state_q <= StVerifyRd;
                    end
`else
                    state_q      <= StIdle;
                    load_ready_q <= 1'b1;
`endif
                end
`ifdef ROM_PAGE_CTRL_VERIFY_EN
                StVerifyRd: begin
                    if (mode_chg) begin
                        state_q      <= StIdle;
                        load_ready_q <= 1'b1;
                    end else begin
                        state_q <= StVerifyCmp;
                    end
                end
                StVerifyCmp: begin
                    if (!mode_chg && (rom_rdata != din_q)) begin
                        err_q <= 1'b1;
                    end
                    state_q      <= StIdle;
                    load_ready_q <= 1'b1;
                end
`endif
                default: begin
                    state_q      <= StIdle;
                    rom_we_q     <= 1'b0;
                    load_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Scan pointer and display-valid tracking.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode_q     <= MODE_INPUT;
            scan_col_q <= '0;
            col_dly_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            mode_q    <= mode;
            col_dly_q <= scan_col_q;
            if (mode_chg || page_chg) begin
                // The word in flight belongs to the old page/mode: hide it for one cycle.
                scan_col_q <= '0;
                valid_q    <= 1'b0;
            end else begin
                valid_q <= 1'b1;
                if (scan) begin
                    scan_col_q <= scan_col_q + COL_W'(1);
                end
            end
        end
    end

    always_comb begin
        rom_addr = wr_ptr_q;
        if (scan) begin
            rom_addr = {dbg_page, scan_col_q};
        end
`ifdef ROM_PAGE_CTRL_VERIFY_EN
        else if (state_q == StVerifyRd) begin
            rom_addr = wr_addr_q;
        end
`endif
    end

    always_comb begin
        disp_col  = '0;
        disp_data = '0;
        if (valid_q) begin
            disp_col  = scan ? col_dly_q : wr_ptr_q[COL_W-1:0];
            disp_data = scan ? rom_rdata : din;
        end
    end

    assign page       = scan ? PAGE_W'(dbg_page) : PAGE_W'(wr_ptr_q[ADDR_W-1:COL_W]);
    assign rom_we     = rom_we_q;
    assign rom_wdata  = din_q;
    assign load_ready = load_ready_q;
    assign load_done  = load_done_q;
    assign disp_valid = valid_q;
`ifdef ROM_PAGE_CTRL_VERIFY_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
